// File: rtl/emio_ctrl_if.sv
// Signal bundle between the PS7 EMIO GPIO bus and the control conditioner.
// The gpio_i readback exists only when EMIO_CTRL_READBACK_EN is defined.
interface emio_ctrl_if #(
  parameter int WIDTH = 2
);
  logic [WIDTH-1:0] gpio_o;
  logic [WIDTH-1:0] level;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
`ifdef EMIO_CTRL_READBACK_EN
  logic [WIDTH-1:0] gpio_i;

  modport master (
    output gpio_o,
    input  level,
    input  rise,
    input  fall,
    input  gpio_i
  );

  modport slave (
    input  gpio_o,
    output level,
    output rise,
    output fall,
    output gpio_i
  );
`else
  modport master (
    output gpio_o,
    input  level,
    input  rise,
    input  fall
  );

  modport slave (
    input  gpio_o,
    output level,
    output rise,
    output fall
  );
`endif
endinterface

// File: rtl/emio_ctrl_conditioner.sv
// Per-bit synchronizer, consecutive-sample debounce, polarity map and edge pulses
// for PS7 EMIO GPIO control lines. Define EMIO_CTRL_READBACK_EN to add gpio_i.
module emio_ctrl_conditioner #(
  parameter int               WIDTH           = 2,
  parameter int               SYNC_STAGES     = 2,
  parameter int               DEBOUNCE_CYCLES = 16,
  parameter logic [WIDTH-1:0] ACTIVE_LOW      = {WIDTH{1'b1}}
) (
  input logic        clk,
  input logic        rst_n,
  emio_ctrl_if.slave bus
);

  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync_d [SYNC_STAGES];
  logic [CNT_W-1:0] cnt_q  [WIDTH];
  logic [CNT_W-1:0] cnt_d  [WIDTH];
  logic [WIDTH-1:0] sync_last;
  logic [WIDTH-1:0] filt_q,  filt_d;
  logic [WIDTH-1:0] level_q, level_d;
  logic [WIDTH-1:0] rise_q,  rise_d;
  logic [WIDTH-1:0] fall_q,  fall_d;

  // gpio_o is asynchronous to clk; the first stage may go metastable.
  always_comb begin
    sync_d[0] = bus.gpio_o;
    for (int s = 1; s < SYNC_STAGES; s++) begin
      sync_d[s] = sync_q[s-1];
    end
  end

  assign sync_last = sync_q[SYNC_STAGES-1];

  // A single matching sample discards all accumulated credit.
  always_comb begin
    // NOTE: every output of this block gets a default before any branch, so no latch is inferred.
    filt_d = filt_q;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (sync_last[i] != filt_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          filt_d[i] = sync_last[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // level follows filt on the same edge; pulses mark the cycle level holds its new value.
  always_comb begin
    level_d = filt_d ^ ACTIVE_LOW;
    rise_d  = level_d & ~level_q;
    fall_d  = ~level_d & level_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the sync and counter arrays are small flop banks, not RAM, so they are reset like any register.
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= '0;
      end
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
      filt_q  <= '0;
      level_q <= ACTIVE_LOW;
      rise_q  <= '0;
      fall_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_d[s];
      end
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      filt_q  <= filt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign bus.level = level_q;
  assign bus.rise  = rise_q;
  assign bus.fall  = fall_q;

`ifdef EMIO_CTRL_READBACK_EN
  // Raw-polarity accepted value, read back by software through EMIOGPIOI.
  logic [WIDTH-1:0] gpio_i_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gpio_i_q <= '0;
    end else begin
      gpio_i_q <= filt_d;
    end
  end

  assign bus.gpio_i = gpio_i_q;
`endif

endmodule

// File: tb/tb_emio_ctrl_conditioner.sv
// Self-checking bench for emio_ctrl_conditioner: directed scenarios plus random
// toggling, compared every cycle against a sliding-window reference model.
module tb_emio_ctrl_conditioner;

  localparam int               WIDTH = 2;
  localparam int               SYNC  = 2;
  localparam int               DEB   = 4;
  localparam logic [WIDTH-1:0] AL    = 2'b11;
  localparam int               LAT   = SYNC + DEB;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  emio_ctrl_if #(.WIDTH(WIDTH)) bus ();

  emio_ctrl_conditioner #(
    .WIDTH          (WIDTH),
    .SYNC_STAGES    (SYNC),
    .DEBOUNCE_CYCLES(DEB),
    .ACTIVE_LOW     (AL)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: input samples delayed SYNC edges, accepted once the last
  // DEB delayed samples all disagree with the accepted value.
  logic [WIDTH-1:0] in_hist  [$];
  logic [WIDTH-1:0] syn_hist [$];
  logic [WIDTH-1:0] m_filt, m_level, m_rise, m_fall;

  function automatic void model_reset();
    in_hist.delete();
    syn_hist.delete();
    m_filt  = '0;
    m_level = AL;
    m_rise  = '0;
    m_fall  = '0;
  endfunction

  function automatic void model_edge(input logic [WIDTH-1:0] din);
    logic [WIDTH-1:0] syn;
    logic [WIDTH-1:0] nf;
    logic [WIDTH-1:0] prev;
    bit               all_diff;
    syn = (in_hist.size() == SYNC) ? in_hist[0] : '0;
    in_hist.push_back(din);
    if (in_hist.size() > SYNC) void'(in_hist.pop_front());
    syn_hist.push_back(syn);
    if (syn_hist.size() > DEB) void'(syn_hist.pop_front());
    nf = m_filt;
    for (int b = 0; b < WIDTH; b++) begin
      all_diff = (syn_hist.size() == DEB);
      foreach (syn_hist[k]) begin
        if (syn_hist[k][b] == m_filt[b]) all_diff = 1'b0;
      end
      if (all_diff) nf[b] = ~m_filt[b];
    end
    prev    = m_level;
    m_filt  = nf;
    m_level = nf ^ AL;
    m_rise  = m_level & ~prev;
    m_fall  = prev & ~m_level;
  endfunction

  // One clock: model follows the rising edge, outputs compared on the falling edge.
  task automatic tick();
    @(posedge clk);
    if (!rst_n) model_reset();
    else        model_edge(bus.gpio_o);
    @(negedge clk);
    check("level", bus.level, m_level);
    check("rise",  bus.rise,  m_rise);
    check("fall",  bus.fall,  m_fall);
`ifdef EMIO_CTRL_READBACK_EN
    check("gpio_i", bus.gpio_i, m_filt);
`endif
  endtask

  // Ticks until level changes (n = edges taken) or the budget runs out (n = -1).
  task automatic wait_change(input int maxc, output int n,
                             output logic [WIDTH-1:0] seen_rise,
                             output logic [WIDTH-1:0] seen_fall);
    logic [WIDTH-1:0] start;
    start     = bus.level;
    n         = -1;
    seen_rise = '0;
    seen_fall = '0;
    for (int c = 1; c <= maxc; c++) begin
      tick();
      seen_rise |= bus.rise;
      seen_fall |= bus.fall;
      if (bus.level != start) begin
        n = c;
        break;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int               n;
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] f;
    total = 0;
    bad   = 0;

    // 1: reset state and quiet hold
    rst_n      = 1'b0;
    bus.gpio_o = '0;
    model_reset();
    repeat (3) tick();
    check("s1_rst_level", bus.level, 2'b11);
    rst_n = 1'b1;
    wait_change(20, n, r, f);
    check("s1_hold_nochg", n, -1);
    check("s1_hold_level", bus.level, 2'b11);
    check("s1_pulses", {r, f}, 4'b0000);

    // 2 (and 6): single bit, exact latency and pulse
    bus.gpio_o = 2'b01;
    wait_change(LAT + 4, n, r, f);
    check("s2_latency", n, LAT);
    check("s2_level", bus.level, 2'b10);
    check("s2_fall", bus.fall, 2'b01);
    check("s2_no_rise", r, 2'b00);
`ifdef EMIO_CTRL_READBACK_EN
    check("s6_gpio_i", bus.gpio_i, 2'b01);
`endif
    tick();
    check("s2_fall_1cyc", bus.fall, 2'b00);

    // 3: short glitch rejected, then a held change accepted
    bus.gpio_o = 2'b11;
    repeat (3) tick();
    bus.gpio_o = 2'b01;
    wait_change(12, n, r, f);
    check("s3_glitch_nochg", n, -1);
    check("s3_glitch_pulses", {r, f}, 4'b0000);
    check("s3_glitch_level", bus.level, 2'b10);
    bus.gpio_o = 2'b11;
    wait_change(LAT + 4, n, r, f);
    check("s3_latency", n, LAT);
    check("s3_level", bus.level, 2'b00);
    check("s3_fall", bus.fall, 2'b10);

    // 4: both bits together
    bus.gpio_o = 2'b00;
    wait_change(LAT + 4, n, r, f);
    check("s4_lat_a", n, LAT);
    check("s4_rise_both", bus.rise, 2'b11);
    check("s4_level_a", bus.level, 2'b11);
    bus.gpio_o = 2'b11;
    wait_change(LAT + 4, n, r, f);
    check("s4_lat_b", n, LAT);
    check("s4_fall_both", bus.fall, 2'b11);
    check("s4_level_b", bus.level, 2'b00);
    bus.gpio_o = 2'b00;
    wait_change(LAT + 4, n, r, f);
    check("s4_lat_c", n, LAT);
    check("s4_rise_again", bus.rise, 2'b11);
    check("s4_level_c", bus.level, 2'b11);
    repeat (LAT) tick();

    // 5: reset mid-qualification restarts the full latency
    bus.gpio_o = 2'b01;
    repeat (SYNC + 2) tick();
    rst_n = 1'b0;
    model_reset();
    #1;
    check("s5_rst_level", bus.level, 2'b11);
    repeat (3) tick();
    rst_n = 1'b1;
    wait_change(LAT + 4, n, r, f);
    check("s5_latency", n, LAT);
    check("s5_level", bus.level, 2'b10);

    // Random toggling with occasional resets, checked every cycle by the model
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < WIDTH; b++) begin
        if ($urandom_range(0, 7) == 0) bus.gpio_o[b] = ~bus.gpio_o[b];
      end
      if ($urandom_range(0, 499) == 0) begin
        rst_n = 1'b0;
        model_reset();
        repeat (2) tick();
        rst_n = 1'b1;
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/emio_ctrl_conditioner.md
Name: emio_ctrl_conditioner

Overview:
- Conditions PS7 EMIO GPIO output lines before they reach fabric control logic, e.g. counter enable and count direction.
- Per bit: multi-flop synchronizer, then consecutive-sample debounce filter, then polarity mapping, then registered level plus single-cycle rise/fall pulses.
- Sits between the PS7 EMIOGPIOO bus and the LED counter stage. Gives that stage glitch-free, clock-aligned controls.

Parameters:
- WIDTH, 2, number of EMIO GPIO bits conditioned (bit i maps to gpio_o[i]).
- SYNC_STAGES, 2, synchronizer flop depth per bit; legal range 2..4.
- DEBOUNCE_CYCLES, 16, consecutive synced cycles a new value must persist before acceptance; legal range 1..65535.
- ACTIVE_LOW, {WIDTH{1'b1}}, per-bit mask; bit set means level[i] = ~filtered raw value.

Ports:
- clk  in  1  fabric clock (BUFG-driven); all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset; deassertion synchronous to clk externally.
- gpio_o  in  WIDTH  raw PS7 EMIOGPIOO bits; asynchronous to clk.
- level  out  WIDTH  debounced, polarity-mapped control levels.
- rise  out  WIDTH  1-cycle pulse when level[i] goes 0->1.
- fall  out  WIDTH  1-cycle pulse when level[i] goes 1->0.
- gpio_i  out  WIDTH  filtered raw readback; present only with EMIO_CTRL_READBACK_EN.

Behaviour:
- Reset, while rst_n=0 asynchronously:
  - all sync flops, filtered raw values and debounce counters = 0.
  - level = ACTIVE_LOW; rise = 0; fall = 0; gpio_i = 0.
- Synchronizer: plain shift chain of SYNC_STAGES flops per bit. sync[i] is the last stage.
- Debounce state, per bit: filt[i] (accepted raw value), cnt[i] of width $clog2(DEBOUNCE_CYCLES+1).
  - sync[i] == filt[i]: cnt <= 0.
  - sync[i] != filt[i] and cnt < DEBOUNCE_CYCLES-1: cnt <= cnt+1.
  - sync[i] != filt[i] and cnt == DEBOUNCE_CYCLES-1: filt <= sync, cnt <= 0.
  - A single differing-to-matching transition restarts qualification from zero. No partial credit is kept.
  - DEBOUNCE_CYCLES=1: a new synced value is accepted on the next edge.
  - cnt never exceeds DEBOUNCE_CYCLES-1; no wrap-around is possible.
- Output mapping:
  - level[i] is a register loaded with filt_next[i] ^ ACTIVE_LOW[i], where filt_next is the value filt takes on this edge. level updates on the same edge as filt.
  - rise[i]/fall[i] are registered. Asserted for exactly the one cycle in which level[i] holds its new value. Deasserted otherwise.
- Latency: gpio_o[i] stable from edge 0 gives level[i] change after exactly SYNC_STAGES + DEBOUNCE_CYCLES rising edges.
- Bit independence: bits filter independently. Simultaneous changes on several bits, each held long enough, update in the same cycle. rise and fall may both be nonzero on different bits in one cycle.
- Reset mid-qualification: the counter is discarded. After release the full SYNC_STAGES + DEBOUNCE_CYCLES latency applies again, measured from the first clk edge with rst_n=1.
- Reset does not itself generate pulses. The level transition from ACTIVE_LOW on leaving reset occurs only through normal filtering, and only if the input differs.
- Pulse phases: no pulse is ever generated without a corresponding level change. Back-to-back accepted changes on one bit are at least DEBOUNCE_CYCLES apart, so pulses never merge.

Optional Feature:
- Macro EMIO_CTRL_READBACK_EN.
- Defined: port gpio_i exists and is registered = filt (raw polarity, pre-ACTIVE_LOW), updated on the same edge as level. The top level wires it to PS7 EMIOGPIOI so software reads the accepted value; reset value 0.
- Undefined: port gpio_i and its register are absent. All other behaviour is identical.

Test Plan (WIDTH=2, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, ACTIVE_LOW=2'b11):
1. Assert rst_n=0 with gpio_o=2'b00, then release -> level=2'b11, rise=fall=2'b00, and level holds 2'b11 for 20 cycles.
2. After reset, drive gpio_o[0]=1 at edge 0 and hold -> level changes 2'b11->2'b10 on edge 6 exactly, fall=2'b01 for one cycle, rise=0 throughout.
3. Glitch: gpio_o[1]=1 for 3 cycles, then 0 -> level stays 2'b11 and no pulses. Then hold 1 -> change after 6 edges from the final rising input.
4. Drive both bits 00->11 on the same edge, wait for acceptance, then both 11->00 -> fall=2'b11 for one cycle, later rise=2'b11 for one cycle; level toggles 11->00->11.
5. Hold gpio_o=2'b01; at 2 edges into debounce assert rst_n=0 for 3 cycles -> level=2'b11 during reset. After release, level=2'b10 only 6 edges after the first post-reset edge.
6. With EMIO_CTRL_READBACK_EN: repeat scenario 2 -> gpio_i goes 2'b00->2'b01 on the same edge as level goes to 2'b10. Without the macro, the bench compiles with no gpio_i port.
